// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared constants and state encoding for the system command controller.
package sys_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register file slots that hold the ALU operands.
  localparam int unsigned ADDR_OP_A = 0;
  localparam int unsigned ADDR_OP_B = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

endpackage

// File: rtl/sys_cmd_tx_push.sv
// Pushes one or two bytes of a result word into the TX FIFO, low byte first,
// stalling while the FIFO is full. The first byte can go out on the same edge
// the word is loaded, so a response leaves one cycle after its valid pulse.
module sys_cmd_tx_push #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    load,
  input  logic [2*DATA_WIDTH-1:0] word,
  input  logic                    two,
  input  logic                    fifo_full,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_inc,
  output logic                    fire_hi,
  output logic                    done
);

  logic [2*DATA_WIDTH-1:0] word_q, word_eff;
  logic [1:0]              rem_q, rem_eff;
  logic                    two_q, two_eff;
  logic                    fire;

  // Merge a fresh load with the held word so a load can push immediately.
  always_comb begin
    word_eff = load ? word : word_q;
    rem_eff  = load ? (two ? 2'd2 : 2'd1) : rem_q;
    two_eff  = load ? two : two_q;
    fire     = (rem_eff != 2'd0) && !fifo_full;
    fire_hi  = fire && (rem_eff == 2'd1) && two_eff;
  end

  assign done = (rem_q == 2'd0);

  // Byte shift-out and push strobe.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word_q  <= '0;
      rem_q   <= 2'd0;
      two_q   <= 1'b0;
      wr_data <= '0;
      wr_inc  <= 1'b0;
    end else begin
      wr_inc <= fire;
      two_q  <= two_eff;
      if (fire) begin
        wr_data <= word_eff[DATA_WIDTH-1:0];
        word_q  <= word_eff >> DATA_WIDTH;
        rem_q   <= 2'(rem_eff - 2'd1);
      end else begin
        word_q  <= word_eff;
        rem_q   <= rem_eff;
      end
    end
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Decodes UART command frames into register-file and ALU operations and
// returns read data / ALU results through the TX FIFO.
//
// state       | meaning
// ST_IDLE     | waiting for an opcode byte
// ST_WR_ADDR  | reg write: waiting for address byte
// ST_WR_DATA  | reg write: waiting for data byte
// ST_RD_ADDR  | reg read: waiting for address byte
// ST_RD_WAIT  | reg read: waiting for RdData_Valid
// ST_ALU_A    | ALU: waiting for operand A (written to slot 0)
// ST_ALU_B    | ALU: waiting for operand B (written to slot 1)
// ST_ALU_FUN  | ALU: clock enabled, waiting for function byte
// ST_ALU_WAIT | ALU: clock enabled, waiting for ALU_OUT_VLD
// ST_TX_LO    | pushing / holding the low response byte
// ST_TX_HI    | high ALU result byte pushed, returning to idle
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic                    RX_ERR,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    WR_INC,
  output logic                    BUSY
);

  import sys_cmd_ctrl_pkg::*;

  state_t                  state, state_n;
  logic                    wr_en_n, rd_en_n, alu_en_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   wr_data_n;
  logic [FUN_WIDTH-1:0]    fun_n;
  logic                    rx_ok, rx_bad, consuming;
  logic                    tx_load, tx_two, tx_fire_hi, tx_done;
  logic [2*DATA_WIDTH-1:0] tx_word;

  assign rx_ok  = RX_D_VLD && !RX_ERR;
  assign rx_bad = RX_D_VLD && RX_ERR;

  // Only byte-consuming states abort on a bad byte; in wait/TX states every
  // incoming byte is dropped anyway, so an in-flight response still completes.
  assign consuming = (state inside {ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR,
                                    ST_ALU_A, ST_ALU_B, ST_ALU_FUN});

  // Next-state and next-output decode.
  always_comb begin
    state_n   = state;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    alu_en_n  = 1'b0;
    addr_n    = Address;
    wr_data_n = WrData;
    fun_n     = ALU_FUN;
    tx_load   = 1'b0;
    tx_two    = 1'b1;
    tx_word   = ALU_OUT;
    if (rx_bad && consuming) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (rx_ok) begin
          case (RX_P_DATA)
            CMD_RF_WR:   state_n = ST_WR_ADDR;
            CMD_RF_RD:   state_n = ST_RD_ADDR;
            CMD_ALU_OP:  state_n = ST_ALU_A;
            CMD_ALU_NOP: state_n = ST_ALU_FUN;
            default:     state_n = ST_IDLE;
          endcase
        end
        ST_WR_ADDR: if (rx_ok) begin
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_n = ST_WR_DATA;
        end
        ST_WR_DATA: if (rx_ok) begin
          wr_en_n   = 1'b1;
          wr_data_n = RX_P_DATA;
          state_n   = ST_IDLE;
        end
        ST_RD_ADDR: if (rx_ok) begin
          rd_en_n = 1'b1;
          addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_n = ST_RD_WAIT;
        end
        ST_RD_WAIT: if (RdData_Valid) begin
          tx_load = 1'b1;
          tx_two  = 1'b0;
          tx_word = {{DATA_WIDTH{1'b0}}, RdData};
          state_n = ST_TX_LO;
        end
        ST_ALU_A: if (rx_ok) begin
          wr_en_n   = 1'b1;
          addr_n    = ADDR_WIDTH'(ADDR_OP_A);
          wr_data_n = RX_P_DATA;
          state_n   = ST_ALU_B;
        end
        ST_ALU_B: if (rx_ok) begin
          wr_en_n   = 1'b1;
          addr_n    = ADDR_WIDTH'(ADDR_OP_B);
          wr_data_n = RX_P_DATA;
          state_n   = ST_ALU_FUN;
        end
        ST_ALU_FUN: if (rx_ok) begin
          alu_en_n = 1'b1;
          fun_n    = RX_P_DATA[FUN_WIDTH-1:0];
          state_n  = ST_ALU_WAIT;
        end
        ST_ALU_WAIT: if (ALU_OUT_VLD) begin
          tx_load = 1'b1;
          state_n = ST_TX_LO;
        end
        ST_TX_LO: begin
          if (tx_fire_hi)   state_n = ST_TX_HI;
          else if (tx_done) state_n = ST_IDLE;
        end
        ST_TX_HI: if (tx_done) state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State register and registered command outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      Address <= '0;
      WrData  <= '0;
      ALU_EN  <= 1'b0;
      ALU_FUN <= '0;
      CLK_EN  <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_n;
      WrEn    <= wr_en_n;
      RdEn    <= rd_en_n;
      Address <= addr_n;
      WrData  <= wr_data_n;
      ALU_EN  <= alu_en_n;
      ALU_FUN <= fun_n;
      CLK_EN  <= (state_n == ST_ALU_FUN) || (state_n == ST_ALU_WAIT);
      BUSY    <= (state_n != ST_IDLE);
    end
  end

  sys_cmd_tx_push #(.DATA_WIDTH(DATA_WIDTH)) u_tx_push (
    .CLK       (CLK),
    .RST       (RST),
    .load      (tx_load),
    .word      (tx_word),
    .two       (tx_two),
    .fifo_full (FIFO_FULL),
    .wr_data   (WR_DATA),
    .wr_inc    (WR_INC),
    .fire_hi   (tx_fire_hi),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Bench for sys_cmd_ctrl: table of command frames, event scoreboard fed from
// the frame contents, plus directed RX-error, reset and spurious-pulse cases.
module tb_sys_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0, RX_ERR = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0, FIFO_FULL = 1'b0;
  logic        WrEn, RdEn, ALU_EN, CLK_EN, WR_INC, BUSY;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, WR_DATA;

  int n_assert = 0;
  int n_fail   = 0;
  int ev_seen  = 0;

  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ALU = 2'd2, K_TX = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          nb;
    logic [15:0] resp;
    int          n_ev;
    bit          full;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[9];

  always #5 CLK = ~CLK;

  sys_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RX_ERR(RX_ERR), .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
    .WR_DATA(WR_DATA), .WR_INC(WR_INC), .BUSY(BUSY)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_assert++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  task automatic check_ev(input string nm, input ev_t got);
    ev_t e;
    n_assert++;
    ev_seen++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event got %0h required none", nm, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %0h required %0h", nm, got, e);
      end
    end
  endtask

  // Output monitor: every strobe becomes an event compared against the queue.
  always @(negedge CLK) begin
    if (!RST) begin
      if (WrEn)   check_ev("ev_wr",  {K_WR, Address, WrData});
      if (RdEn)   check_ev("ev_rd",  {K_RD, Address, 8'h00});
      if (ALU_EN) check_ev("ev_alu", {K_ALU, ALU_FUN, 8'h00});
      if (WR_INC) begin
        check_ev("ev_tx", {K_TX, 4'h0, WR_DATA});
        check("push_while_full", FIFO_FULL, 0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    RX_ERR    = e;
    tick();
    RX_D_VLD  = 1'b0;
    RX_ERR    = 1'b0;
  endtask

  function automatic logic [7:0] vbyte(input vec_t v, input int i);
    case (i)
      0: return v.b0;
      1: return v.b1;
      2: return v.b2;
      default: return v.b3;
    endcase
  endfunction

  // Expected event stream of a well-formed frame.
  task automatic push_model(input vec_t v);
    case (v.b0)
      8'hAA: exp_q.push_back({K_WR, v.b1[3:0], v.b2});
      8'hBB: begin
        exp_q.push_back({K_RD, v.b1[3:0], 8'h00});
        exp_q.push_back({K_TX, 4'h0, v.resp[7:0]});
      end
      8'hCC: begin
        exp_q.push_back({K_WR, 4'd0, v.b1});
        exp_q.push_back({K_WR, 4'd1, v.b2});
        exp_q.push_back({K_ALU, v.b3[3:0], 8'h00});
        exp_q.push_back({K_TX, 4'h0, v.resp[7:0]});
        exp_q.push_back({K_TX, 4'h0, v.resp[15:8]});
      end
      8'hDD: begin
        exp_q.push_back({K_ALU, v.b1[3:0], 8'h00});
        exp_q.push_back({K_TX, 4'h0, v.resp[7:0]});
        exp_q.push_back({K_TX, 4'h0, v.resp[15:8]});
      end
      default: ;
    endcase
  endtask

  task automatic run_cmd(input vec_t v);
    int seen0 = ev_seen;
    int t;
    push_model(v);
    for (int i = 0; i < v.nb; i++) begin
      send_byte(vbyte(v, i), 1'b0);
      if (i < v.nb - 1) idle(2);
    end
    case (v.b0)
      8'hAA: check("wr_latency", WrEn, 1);
      8'hBB: check("rd_latency", RdEn, 1);
      8'hCC, 8'hDD: begin
        check("alu_latency", ALU_EN, 1);
        check("clk_en_start", CLK_EN, 1);
      end
      default: check("unknown_idle", BUSY, 0);
    endcase
    if (v.b0 == 8'hBB) begin
      idle(2);
      RdData = v.resp[7:0];
      RdData_Valid = 1'b1;
      tick();
      RdData_Valid = 1'b0;
      check("rd_tx_latency", WR_INC, 1);
      check("rd_tx_data", WR_DATA, v.resp[7:0]);
    end
    if (v.b0 == 8'hCC || v.b0 == 8'hDD) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check("clk_en_wait", CLK_EN, 1);
      end
      if (v.full) FIFO_FULL = 1'b1;
      ALU_OUT = v.resp;
      ALU_OUT_VLD = 1'b1;
      tick();
      ALU_OUT_VLD = 1'b0;
      check("clk_en_drop", CLK_EN, 0);
      if (v.full) begin
        check("no_push_full", WR_INC, 0);
        for (int k = 0; k < 9; k++) begin
          tick();
          check("no_push_full", WR_INC, 0);
        end
        FIFO_FULL = 1'b0;
        tick();
        check("push_after_full", WR_INC, 1);
      end else begin
        check("alu_tx_latency", WR_INC, 1);
      end
    end
    for (t = 0; t < 40 && BUSY; t++) tick();
    check("busy_clear", BUSY, 0);
    idle(2);
    check("event_count", ev_seen - seen0, v.n_ev);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    vec_t v;
    vecs[0] = '{8'hAA, 8'h05, 8'h3C, 8'h00, 3, 16'h0000, 1, 1'b0};
    vecs[1] = '{8'hBB, 8'h05, 8'h00, 8'h00, 2, 16'h003C, 2, 1'b0};
    vecs[2] = '{8'hCC, 8'h12, 8'h34, 8'h00, 4, 16'h0046, 5, 1'b0};
    vecs[3] = '{8'hDD, 8'h02, 8'h00, 8'h00, 2, 16'hBEEF, 3, 1'b1};
    vecs[4] = '{8'h55, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 0, 1'b0};
    vecs[5] = '{8'hAA, 8'h0F, 8'hFF, 8'h00, 3, 16'h0000, 1, 1'b0};
    vecs[6] = '{8'hBB, 8'hF7, 8'h00, 8'h00, 2, 16'h00A5, 2, 1'b0};
    vecs[7] = '{8'hCC, 8'hFF, 8'h01, 8'h0F, 4, 16'h1234, 5, 1'b0};
    vecs[8] = '{8'hDD, 8'h13, 8'h00, 8'h00, 2, 16'h8001, 3, 1'b0};

    idle(3);
    check("reset_outputs",
          {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, WR_DATA, WR_INC, BUSY}, 0);
    RST = 1'b0;
    idle(2);

    foreach (vecs[i]) run_cmd(vecs[i]);

    // Bad byte mid-frame aborts, then a clean write goes through.
    seen0 = ev_seen;
    send_byte(8'hAA, 1'b0); idle(2);
    send_byte(8'h05, 1'b0); idle(2);
    send_byte(8'h3C, 1'b1);
    check("err_idle", BUSY, 0);
    idle(3);
    check("err_no_write", ev_seen - seen0, 0);
    v = '{8'hAA, 8'h06, 8'h77, 8'h00, 3, 16'h0000, 1, 1'b0};
    run_cmd(v);

    // Reset while waiting on the ALU; the late result must not be pushed.
    seen0 = ev_seen;
    exp_q.push_back({K_ALU, 4'h2, 8'h00});
    send_byte(8'hDD, 1'b0); idle(2);
    send_byte(8'h02, 1'b0);
    tick();
    check("clk_en_before_rst", CLK_EN, 1);
    RST = 1'b1;
    tick();
    check("rst_outputs",
          {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, WR_DATA, WR_INC, BUSY}, 0);
    RST = 1'b0;
    tick();
    ALU_OUT = 16'hCAFE;
    ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    idle(4);
    check("rst_events", ev_seen - seen0, 1);
    check("rst_busy", BUSY, 0);
    check("rst_queue_empty", exp_q.size(), 0);

    // Response valids outside their wait states are ignored.
    seen0 = ev_seen;
    RdData = 8'h99; RdData_Valid = 1'b1; ALU_OUT_VLD = 1'b1;
    tick();
    RdData_Valid = 1'b0; ALU_OUT_VLD = 1'b0;
    idle(4);
    check("spurious_valid", ev_seen - seen0, 0);
    check("spurious_busy", BUSY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
